fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 143 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller between the PC register, instruction
// memory and the decode stage.
//
// Ports
//   CLK        in   clock, all state on rising edge
//   Reset_L    in   synchronous active-low reset
//   pc         in   current PC from the PC register
//   PC_write   out  PC register load enable
//   npc        out  next PC value for the PC register
//   br_taken   in   one-cycle redirect pulse from execute
//   br_target  in   redirect address, valid with br_taken
//   imem_req   out  instruction memory request
//   imem_addr  out  instruction memory address
//   imem_ack   in   memory response valid (may coincide with imem_req)
//   imem_data  in   instruction word, valid with imem_ack
//   id_stall   in   decode cannot accept a new instruction
//   id_valid   out  id_instr/id_pc4 hold a live instruction
//   id_instr   out  registered instruction to decode
//   id_pc4     out  registered fetch address + 4
module fetch_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic [31:0] pc,
  output logic        PC_write,
  output logic [31:0] npc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

  state_e      state_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_pc4_q;
  logic [31:0] drain_addr_q;
  logic [31:0] pc4;
  logic        slot_free;

  assign pc4       = pc + 32'd4;  // wraps modulo 2^32
  assign slot_free = !id_valid || !id_stall;

  // Request and PC-update signals are combinational so a zero-wait memory
  // sustains one instruction per cycle.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    PC_write  = 1'b0;
    npc       = pc4;
    if (Reset_L) begin
      imem_req  = (state_q == StFetch) || (state_q == StDrain);
      // In DRAIN the abandoned request must keep its original address.
      imem_addr = (state_q == StDrain) ? drain_addr_q : pc;
      if (br_taken) begin
        PC_write = 1'b1;
        npc      = br_target;
      end else if (state_q == StFetch && imem_ack) begin
        PC_write = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q      <= StIdle;
      id_valid     <= 1'b0;
      id_instr     <= NOP_INSTR;
      id_pc4       <= 32'd0;
      skid_instr_q <= 32'd0;
      skid_pc4_q   <= 32'd0;
      drain_addr_q <= 32'd0;
    end else if (br_taken) begin
      // Redirect flushes the decode slot and any skid contents.
      id_valid     <= 1'b0;
      id_instr     <= NOP_INSTR;
      skid_instr_q <= 32'd0;
      skid_pc4_q   <= 32'd0;
      case (state_q)
        StFetch: begin
          if (!imem_ack) begin
            drain_addr_q <= pc;
            state_q      <= StDrain;
          end
        end
        StDrain: begin
          if (imem_ack) state_q <= StFetch;
        end
        default: state_q <= StFetch;
      endcase
    end else begin
      case (state_q)
        StIdle: begin
          state_q <= StFetch;
          if (id_valid && !id_stall) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
          end
        end
        StFetch: begin
          if (imem_ack && slot_free) begin
            id_valid <= 1'b1;
            id_instr <= imem_data;
            id_pc4   <= pc4;
          end else if (imem_ack) begin
            // Decode is stalled on a live instruction: park the response.
            skid_instr_q <= imem_data;
            skid_pc4_q   <= pc4;
            state_q      <= StHold;
          end else if (id_valid && !id_stall) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
          end
        end
        StHold: begin
          if (!id_stall) begin
            id_valid <= 1'b1;
            id_instr <= skid_instr_q;
            id_pc4   <= skid_pc4_q;
            state_q  <= StFetch;
          end
        end
        StDrain: begin
          if (imem_ack) state_q <= StFetch;
          if (id_valid && !id_stall) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl. The bench drives pc by hand,
// standing in for the PC register.
module tb_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic [31:0] pc;
  logic        PC_write;
  logic [31:0] npc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;

  int n_cmp = 0;
  int n_err = 0;

  fetch_ctrl #(.NOP_INSTR(32'h0000_0000)) dut (
    .CLK       (CLK),
    .Reset_L   (Reset_L),
    .pc        (pc),
    .PC_write  (PC_write),
    .npc       (npc),
    .br_taken  (br_taken),
    .br_target (br_target),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .id_stall  (id_stall),
    .id_valid  (id_valid),
    .id_instr  (id_instr),
    .id_pc4    (id_pc4)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset_L = 1'b0; pc = 32'h100; br_taken = 1'b0; br_target = 32'h0;
    imem_ack = 1'b0; imem_data = 32'h0; id_stall = 1'b0;

    // Reset
    tick();
    check_eq("rst_valid", {31'd0, id_valid}, 32'd0);
    check_eq("rst_instr", id_instr, 32'h0);
    check_eq("rst_pc4", id_pc4, 32'h0);
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_pcw", {31'd0, PC_write}, 32'd0);
    Reset_L = 1'b1; #1;
    check_eq("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    check_eq("fetch_req", {31'd0, imem_req}, 32'd1);
    check_eq("fetch_addr", imem_addr, 32'h100);

    // Ack delayed three cycles: request and address stable, no PC update
    for (int i = 0; i < 3; i++) begin
      check_eq("wait_req", {31'd0, imem_req}, 32'd1);
      check_eq("wait_addr", imem_addr, 32'h100);
      check_eq("wait_pcw", {31'd0, PC_write}, 32'd0);
      check_eq("wait_npc", npc, 32'h104);
      tick();
    end

    // Back-to-back acks 0xA0, 0xA1
    imem_ack = 1'b1; imem_data = 32'hA0; #1;
    check_eq("a0_pcw", {31'd0, PC_write}, 32'd1);
    check_eq("a0_npc", npc, 32'h104);
    tick();
    check_eq("a0_valid", {31'd0, id_valid}, 32'd1);
    check_eq("a0_instr", id_instr, 32'hA0);
    check_eq("a0_pc4", id_pc4, 32'h104);
    pc = 32'h104; imem_data = 32'hA1; #1;
    check_eq("a1_addr", imem_addr, 32'h104);
    check_eq("a1_pcw", {31'd0, PC_write}, 32'd1);
    tick();
    check_eq("a1_instr", id_instr, 32'hA1);
    check_eq("a1_pc4", id_pc4, 32'h108);

    // Ack while decode stalled -> HOLD
    pc = 32'h108; id_stall = 1'b1; imem_data = 32'hB2; #1;
    check_eq("b2_pcw", {31'd0, PC_write}, 32'd1);
    check_eq("b2_npc", npc, 32'h10C);
    tick();
    pc = 32'h10C; imem_ack = 1'b0; #1;
    check_eq("hold_instr", id_instr, 32'hA1);
    check_eq("hold_valid", {31'd0, id_valid}, 32'd1);
    check_eq("hold_req", {31'd0, imem_req}, 32'd0);
    check_eq("hold_pcw", {31'd0, PC_write}, 32'd0);
    tick();
    check_eq("hold2_instr", id_instr, 32'hA1);
    check_eq("hold2_req", {31'd0, imem_req}, 32'd0);
    id_stall = 1'b0;
    tick();
    check_eq("skid_instr", id_instr, 32'hB2);
    check_eq("skid_pc4", id_pc4, 32'h10C);
    check_eq("skid_valid", {31'd0, id_valid}, 32'd1);
    check_eq("resume_req", {31'd0, imem_req}, 32'd1);
    check_eq("resume_addr", imem_addr, 32'h10C);

    // Slot consumed with nothing new -> bubble
    tick();
    check_eq("bubble_valid", {31'd0, id_valid}, 32'd0);
    check_eq("bubble_instr", id_instr, 32'h0);

    // Branch in FETCH without ack -> DRAIN
    br_taken = 1'b1; br_target = 32'h200; #1;
    check_eq("br_pcw", {31'd0, PC_write}, 32'd1);
    check_eq("br_npc", npc, 32'h200);
    tick();
    br_taken = 1'b0; pc = 32'h200; #1;
    check_eq("drain_req", {31'd0, imem_req}, 32'd1);
    check_eq("drain_addr", imem_addr, 32'h10C);
    check_eq("drain_pcw", {31'd0, PC_write}, 32'd0);
    check_eq("drain_npc", npc, 32'h204);
    tick();
    check_eq("drain2_addr", imem_addr, 32'h10C);
    imem_ack = 1'b1; imem_data = 32'hDEAD; #1;
    check_eq("drain_ack_pcw", {31'd0, PC_write}, 32'd0);
    tick();
    imem_ack = 1'b0; #1;
    check_eq("drop_valid", {31'd0, id_valid}, 32'd0);
    check_eq("drop_instr", id_instr, 32'h0);
    check_eq("redir_addr", imem_addr, 32'h200);
    check_eq("redir_req", {31'd0, imem_req}, 32'd1);

    // Branch coincident with ack while decode stalled
    imem_ack = 1'b1; imem_data = 32'hC0;
    tick();
    check_eq("c0_instr", id_instr, 32'hC0);
    pc = 32'h204; id_stall = 1'b1; imem_data = 32'hC1;
    br_taken = 1'b1; br_target = 32'h300; #1;
    check_eq("brack_pcw", {31'd0, PC_write}, 32'd1);
    check_eq("brack_npc", npc, 32'h300);
    tick();
    br_taken = 1'b0; imem_ack = 1'b0; id_stall = 1'b0; pc = 32'h300; #1;
    check_eq("brack_valid", {31'd0, id_valid}, 32'd0);
    check_eq("brack_instr", id_instr, 32'h0);
    check_eq("brack_addr", imem_addr, 32'h300);
    check_eq("brack_req", {31'd0, imem_req}, 32'd1);

    // pc+4 wraps at the top of the address space
    pc = 32'hFFFF_FFFC; #1;
    check_eq("wrap_npc", npc, 32'h0);
    imem_ack = 1'b1; imem_data = 32'hE0;
    tick();
    check_eq("wrap_pc4", id_pc4, 32'h0);
    check_eq("wrap_instr", id_instr, 32'hE0);

    // Reset during an outstanding request with a pending ack
    Reset_L = 1'b0; #1;
    check_eq("rstq_req", {31'd0, imem_req}, 32'd0);
    check_eq("rstq_pcw", {31'd0, PC_write}, 32'd0);
    tick();
    Reset_L = 1'b1; #1;
    check_eq("rstq_valid", {31'd0, id_valid}, 32'd0);
    check_eq("rstq_idle_req", {31'd0, imem_req}, 32'd0);
    check_eq("rstq_idle_pcw", {31'd0, PC_write}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
